// File: rtl/rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_arbiter_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   MEM_ADDR_W / WORD_W : memory address and word widths (byte addresses).
//   ZERO_ADDR/ZERO_WORD : idle values for the memory buses.
//   arb_state_t         : ARB_BOOT (loader owns the memory) / ARB_RUN.
//   rr_last_t           : which of M0/M1 won the most recent RUN grant.
//   mem_wr_t            : bundled byte-masked write port.
// -----------------------------------------------------------------------------
package rom_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int WORD_W     = 32;
    localparam int SEL_W      = WORD_W / 8;

    localparam logic [MEM_ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [WORD_W-1:0]     ZERO_WORD = '0;
    localparam logic [SEL_W-1:0]      SEL_ALL   = '1;

    typedef enum logic {
        ARB_BOOT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } rr_last_t;

    typedef struct packed {
        logic                  en;
        logic [MEM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
        logic [SEL_W-1:0]      sel;
    } mem_wr_t;

endpackage : rom_arbiter_pkg

// File: rtl/rom_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker, purely combinational.
//   req[1:0] in  : request vector, bit 0 = M0, bit 1 = M1
//   last     in  : previous winner (LAST_M0 / LAST_M1)
//   gnt[1:0] out : one-hot grant, all-zero when nobody requests
// A sole requester always wins; on a tie the requester that did not win
// last time is chosen.
// -----------------------------------------------------------------------------
module rr_pick2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  rr_last_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default assigned first so every path drives gnt -- no latch.
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == LAST_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : rr_pick2

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one memory (combinational read port, byte-masked write port) among
// three requesters:
//   M0 instruction fetch (read-only), M1 load/store unit (read/write),
//   M2 boot loader (write-only).
// While in BOOT only M2 is served; after boot_done_i the arbiter stays in RUN
// (until reset) and round-robins M0/M1.  Grants are combinational; read data
// is registered and returned with rvalid one cycle after the grant.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   boot_done_i                    loader finished, BOOT -> RUN
//   m0_*                           fetch request/grant/read return
//   m1_*                           LSU request/grant/read return
//   m2_*                           loader write request/grant
//   mem_*                          memory read address and write port
//   boot_o                         high while in BOOT
//   conflict_cnt_o                 saturating count of RUN cycles where
//                                  M0 and M1 both request
// -----------------------------------------------------------------------------
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_done_i,

    input  logic                  m0_req_i,
    input  logic [MEM_ADDR_W-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [WORD_W-1:0]     m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [MEM_ADDR_W-1:0] m1_addr_i,
    input  logic [WORD_W-1:0]     m1_wdata_i,
    input  logic [SEL_W-1:0]      m1_sel_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [WORD_W-1:0]     m1_rdata_o,

    input  logic                  m2_req_i,
    input  logic [MEM_ADDR_W-1:0] m2_addr_i,
    input  logic [WORD_W-1:0]     m2_wdata_i,
    output logic                  m2_gnt_o,

    output logic [MEM_ADDR_W-1:0] mem_r_addr_o,
    output logic                  mem_w_en_o,
    output logic [MEM_ADDR_W-1:0] mem_w_addr_o,
    output logic [WORD_W-1:0]     mem_w_data_o,
    output logic [SEL_W-1:0]      mem_w_sel_o,
    input  logic [WORD_W-1:0]     mem_r_data_i,

    output logic                  boot_o,
    output logic [CNT_W-1:0]      conflict_cnt_o
);

    arb_state_t       state_q, state_d;
    rr_last_t         last_q;
    logic [1:0]       run_gnt;
    logic             m0_gnt, m1_gnt, m2_gnt;
    logic             m1_rd_gnt;
    logic             conflict;
    mem_wr_t          wr;
    logic [CNT_W-1:0] cnt_q;

    rr_pick2 u_pick (
        .req  ({m1_req_i, m0_req_i}),
        .last (last_q),
        .gnt  (run_gnt)
    );

    // Next state and grants.  Grants are forced low while rst_n is asserted
    // so an asynchronous reset drops them immediately, not at the next edge.
    always_comb begin
        state_d = state_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        m2_gnt  = 1'b0;
        unique case (state_q)
            ARB_BOOT: begin
                m2_gnt = m2_req_i;
                if (boot_done_i) begin
                    state_d = ARB_RUN;
                end
            end
            ARB_RUN: begin
                m0_gnt = run_gnt[0];
                m1_gnt = run_gnt[1];
            end
            default: state_d = ARB_BOOT;
        endcase
        if (!rst_n) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
            m2_gnt = 1'b0;
        end
    end

    assign m1_rd_gnt = m1_gnt & ~m1_we_i;
    assign conflict  = (state_q == ARB_RUN) & m0_req_i & m1_req_i;

    // Memory port steering: at most one grant is active per cycle, so the
    // read address and the write port never have two drivers to choose from.
    always_comb begin
        mem_r_addr_o = ZERO_ADDR;
        wr           = '0;
        if (m0_gnt) begin
            mem_r_addr_o = m0_addr_i;
        end
        if (m1_rd_gnt) begin
            mem_r_addr_o = m1_addr_i;
        end
        if (m1_gnt && m1_we_i) begin
            wr = '{en: 1'b1, addr: m1_addr_i, data: m1_wdata_i, sel: m1_sel_i};
        end
        if (m2_gnt) begin
            wr = '{en: 1'b1, addr: m2_addr_i, data: m2_wdata_i, sel: SEL_ALL};
        end
    end

    assign mem_w_en_o   = wr.en;
    assign mem_w_addr_o = wr.addr;
    assign mem_w_data_o = wr.data;
    assign mem_w_sel_o  = wr.sel;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_BOOT;
            last_q      <= LAST_M1;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= ZERO_WORD;
            m1_rdata_o  <= ZERO_WORD;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;

            if (m0_gnt) begin
                last_q <= LAST_M0;
            end else if (m1_gnt) begin
                last_q <= LAST_M1;
            end

            m0_rvalid_o <= m0_gnt;
            m1_rvalid_o <= m1_rd_gnt;

            // Read data holds until the next granted read for that port.
            if (m0_gnt) begin
                m0_rdata_o <= mem_r_data_i;
            end
            if (m1_rd_gnt) begin
                m1_rdata_o <= mem_r_data_i;
            end

            if (conflict && !(&cnt_q)) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign m0_gnt_o       = m0_gnt;
    assign m1_gnt_o       = m1_gnt;
    assign m2_gnt_o       = m2_gnt;
    assign boot_o         = (state_q == ARB_BOOT);
    assign conflict_cnt_o = cnt_q;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Self-checking bench for rom_arbiter: a behavioural memory drives the read
// port, and a transaction-level reference model predicts grants, read
// returns, and the conflict counter.  A second instance with CNT_W=4 shares
// the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done;
    logic        m0_req, m1_req, m1_we, m2_req;
    logic [31:0] m0_addr, m1_addr, m1_wdata, m2_addr, m2_wdata;
    logic [3:0]  m1_sel;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m2_gnt;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_r_addr, mem_w_addr, mem_w_data, mem_r_data;
    logic        mem_w_en;
    logic [3:0]  mem_w_sel;
    logic        boot;
    logic [15:0] cnt;

    logic        m0_gnt4, m0_rvalid4, m1_gnt4, m1_rvalid4, m2_gnt4;
    logic [31:0] m0_rdata4, m1_rdata4;
    logic [31:0] mem_r_addr4, mem_w_addr4, mem_w_data4;
    logic        mem_w_en4;
    logic [3:0]  mem_w_sel4;
    logic        boot4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    rom_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .boot_done_i(boot_done),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_sel_i(m1_sel), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .m2_req_i(m2_req), .m2_addr_i(m2_addr), .m2_wdata_i(m2_wdata),
        .m2_gnt_o(m2_gnt),
        .mem_r_addr_o(mem_r_addr), .mem_w_en_o(mem_w_en),
        .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data),
        .mem_w_sel_o(mem_w_sel), .mem_r_data_i(mem_r_data),
        .boot_o(boot), .conflict_cnt_o(cnt)
    );

    rom_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .boot_done_i(boot_done),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt4),
        .m0_rvalid_o(m0_rvalid4), .m0_rdata_o(m0_rdata4),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_sel_i(m1_sel), .m1_gnt_o(m1_gnt4),
        .m1_rvalid_o(m1_rvalid4), .m1_rdata_o(m1_rdata4),
        .m2_req_i(m2_req), .m2_addr_i(m2_addr), .m2_wdata_i(m2_wdata),
        .m2_gnt_o(m2_gnt4),
        .mem_r_addr_o(mem_r_addr4), .mem_w_en_o(mem_w_en4),
        .mem_w_addr_o(mem_w_addr4), .mem_w_data_o(mem_w_data4),
        .mem_w_sel_o(mem_w_sel4), .mem_r_data_i(mem_r_data),
        .boot_o(boot4), .conflict_cnt_o(cnt4)
    );

    // ---------------- behavioural memory (64 words) ----------------
    logic [31:0] mem [64];

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    assign mem_r_data = mem[mem_r_addr[7:2]];

    always @(posedge clk)
        if (mem_w_en) mem[mem_w_addr[7:2]] <= merge(mem[mem_w_addr[7:2]], mem_w_data, mem_w_sel);

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [64];
    bit          m_boot;
    int          m_last;          // 0 = M0 won last, 1 = M1 won last
    int          m_cnt, m_cnt4;
    bit          m_rv0, m_rv1;
    logic [31:0] m_rd0, m_rd1;
    bit          m_g0, m_g1, m_g2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_last = 1; m_cnt = 0; m_cnt4 = 0;
        m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
        m_g0 = 0; m_g1 = 0; m_g2 = 0;
    endtask

    task automatic clear_inputs();
        boot_done = 0; m0_req = 0; m1_req = 0; m2_req = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
        m2_addr = '0; m2_wdata = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [5:0] w;
        w = 6'($urandom);
        return {24'h0, w, 2'b00};
    endfunction

    // Called just after a negedge with inputs already applied; returns at the
    // next negedge after the model has advanced over the posedge.
    task automatic cycle();
        bit g0, g1, g2, wr;
        #1;
        g0 = 0; g1 = 0; g2 = 0;
        if (m_boot)                 g2 = m2_req;
        else if (m0_req && m1_req) begin
            if (m_last == 1) g0 = 1; else g1 = 1;
        end
        else if (m0_req)            g0 = 1;
        else if (m1_req)            g1 = 1;
        wr = g2 || (g1 && m1_we);

        check("m0_gnt", m0_gnt, g0);
        check("m1_gnt", m1_gnt, g1);
        check("m2_gnt", m2_gnt, g2);
        check("m0_gnt4", m0_gnt4, g0);
        check("m1_gnt4", m1_gnt4, g1);
        check("boot", boot, m_boot);
        check("m0_rvalid", m0_rvalid, m_rv0);
        check("m1_rvalid", m1_rvalid, m_rv1);
        check("m0_rdata", m0_rdata, m_rd0);
        check("m1_rdata", m1_rdata, m_rd1);
        check("cnt", cnt, m_cnt);
        check("cnt4", cnt4, m_cnt4);
        check("w_en", mem_w_en, wr);
        if (g2) begin
            check("w_addr_m2", mem_w_addr, m2_addr);
            check("w_data_m2", mem_w_data, m2_wdata);
            check("w_sel_m2", mem_w_sel, 4'hF);
        end else if (g1 && m1_we) begin
            check("w_addr_m1", mem_w_addr, m1_addr);
            check("w_data_m1", mem_w_data, m1_wdata);
            check("w_sel_m1", mem_w_sel, m1_sel);
        end else begin
            check("w_addr_idle", mem_w_addr, 32'h0);
        end
        if (g0)                check("r_addr_m0", mem_r_addr, m0_addr);
        else if (g1 && !m1_we) check("r_addr_m1", mem_r_addr, m1_addr);
        else                   check("r_addr_idle", mem_r_addr, 32'h0);

        // advance the model over the coming posedge
        m_rv0 = g0;
        if (g0) m_rd0 = ref_mem[m0_addr[7:2]];
        m_rv1 = g1 && !m1_we;
        if (g1 && !m1_we) m_rd1 = ref_mem[m1_addr[7:2]];
        if (g1 && m1_we) ref_mem[m1_addr[7:2]] = merge(ref_mem[m1_addr[7:2]], m1_wdata, m1_sel);
        if (g2) ref_mem[m2_addr[7:2]] = m2_wdata;
        if (!m_boot && m0_req && m1_req) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (g0) m_last = 0;
        if (g1) m_last = 1;
        if (m_boot && boot_done) m_boot = 0;
        m_g0 = g0; m_g1 = g1; m_g2 = g2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        m0_req = 1; m1_req = 1; m2_req = 1;
        #1;
        check("rst_boot", boot, 1);
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_m2_gnt", m2_gnt, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_cnt", cnt, 0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        clear_inputs();
        do_reset();

        // ---- boot: loader write while fetch waits ----
        m2_req = 1; m2_addr = 32'h10; m2_wdata = 32'hDEADBEEF;
        m0_req = 1; m0_addr = 32'h10;
        #1;
        check("boot_m2_gnt", m2_gnt, 1);
        check("boot_m0_gnt", m0_gnt, 0);
        cycle();
        m2_req = 0; boot_done = 1;
        cycle();
        boot_done = 0;
        cycle();                       // RUN: fetch of 0x10 granted
        m0_req = 0;
        check("boot_read_rvalid", m0_rvalid, 1);
        check("boot_read_data", m0_rdata, 32'hDEADBEEF);
        cycle();

        // ---- round robin from a fresh reset ----
        do_reset();
        boot_done = 1;
        cycle();
        boot_done = 0;
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_m0_gnt", m0_gnt, (i % 2) == 0);
            cycle();
        end
        m0_req = 0; m1_req = 0;
        check("rr_cnt", cnt, 6);
        cycle();

        // ---- byte-masked write ----
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hFFFFFFFF; m1_sel = 4'hF;
        cycle();
        m1_wdata = 32'h11223344; m1_sel = 4'b0101;
        cycle();
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_addr = 32'h20;
        cycle();
        m0_req = 0;
        check("byte_rdata", m0_rdata, 32'hFF22FF44);
        cycle();

        // ---- write then immediate read ----
        m1_req = 1; m1_we = 1; m1_addr = 32'h4; m1_wdata = 32'hA5A5A5A5; m1_sel = 4'hF;
        cycle();
        check("wr_no_rvalid", m1_rvalid, 0);
        m1_we = 0;
        cycle();
        m1_req = 0;
        check("rd_after_wr_rvalid", m1_rvalid, 1);
        check("rd_after_wr_data", m1_rdata, 32'hA5A5A5A5);
        cycle();

        // ---- saturation ----
        do_reset();
        boot_done = 1;
        cycle();
        boot_done = 0;
        m0_req = 1; m0_addr = 32'h8;
        m1_req = 1; m1_we = 0; m1_addr = 32'hC;
        for (int i = 0; i < 20; i++) cycle();
        m0_req = 0; m1_req = 0;
        check("sat_cnt4", cnt4, 15);
        check("sat_cnt16", cnt, 20);
        cycle();

        // ---- reset during a granted read ----
        m0_req = 1; m0_addr = 32'h10;
        #1;
        check("midrst_pre_gnt", m0_gnt, 1);
        rst_n = 0;
        model_reset();
        #1;
        check("midrst_gnt", m0_gnt, 0);
        check("midrst_boot", boot, 1);
        @(posedge clk);
        @(negedge clk);
        check("midrst_rvalid", m0_rvalid, 0);
        check("midrst_cnt", cnt, 0);
        clear_inputs();
        rst_n = 1;
        boot_done = 1;
        cycle();
        boot_done = 0;
        m0_req = 1; m0_addr = 32'h10;
        cycle();
        m0_req = 0;
        check("midrst_mem_kept", m0_rdata, 32'hDEADBEEF);
        cycle();

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 600; i++) begin
            boot_done = (i == 40);
            if (!m0_req || m_g0) begin
                m0_req  = ($urandom_range(0, 2) != 0);
                m0_addr = rand_addr();
            end
            if (!m1_req || m_g1) begin
                m1_req   = ($urandom_range(0, 2) != 0);
                m1_we    = $urandom_range(0, 1) == 1;
                m1_addr  = rand_addr();
                m1_wdata = $urandom;
                m1_sel   = 4'($urandom);
            end
            if (!m2_req || m_g2) begin
                m2_req   = (i < 40) && ($urandom_range(0, 1) == 1);
                m2_addr  = rand_addr();
                m2_wdata = $urandom;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_arbiter
